food_unit: RTL and testbench
============================

Name: food_unit

Overview:
Snake-game food manager, directly upstream of the score/display stage; generates the get_food pulse that stage counts.
- Places food at a pseudo-random free grid cell.
- Checks each candidate against the snake body through a one-cycle occupancy query.
- Detects head-on-food on each snake move tick and emits a single-cycle get_food.
- Obeys the shared 2-bit game_state: 00 play, 01 pause, 10 restart, 11 game over.

Parameters:
GRID_W, 40, grid columns (cells 0..GRID_W-1)
GRID_H, 30, grid rows (cells 0..GRID_H-1)
X_W, 6, column coordinate width
Y_W, 5, row coordinate width
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
game_state  input  2  shared game state code
move_tick  input  1  one-cycle strobe; head_x/head_y just updated
head_x  input  X_W  snake head column
head_y  input  Y_W  snake head row
occ  input  1  body occupancy for the last query; valid the cycle after query_valid
query_valid  output  1  one-cycle occupancy query strobe
cand_x  output  X_W  candidate column under query
cand_y  output  Y_W  candidate row under query
food_valid  output  1  food placed and live
food_x  output  X_W  food column
food_y  output  Y_W  food row
get_food  output  1  one-cycle eat pulse

Behaviour:
- Reset (async, any state): state IDLE, LFSR = LFSR_SEED. All outputs are 0: food_valid, get_food, query_valid, food_x/y and cand_x/y.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock when out of reset, in all states.
- Candidate: x = lfsr[X_W-1:0], y = lfsr[8+Y_W-1:8], both from the current register value.
- FSM states: IDLE, PLACE, CHECK, ARMED.
- game_state == 10 overrides all transitions. Next state is IDLE and food_valid, get_food and query_valid are cleared on the next edge.
- IDLE -> PLACE when game_state == 00.
- PLACE: compute the candidate.
  - If x >= GRID_W or y >= GRID_H: stay in PLACE, no query.
  - Otherwise: register cand_x/cand_y, pulse query_valid for 1 cycle, go to CHECK.
- CHECK (exactly 1 cycle): sample occ.
  - If occ = 1, or cand equals (head_x, head_y): return to PLACE.
  - Otherwise: food_x/y <= cand, food_valid <= 1, go to ARMED.
- ARMED, game_state == 00: on move_tick with head == food, get_food = 1 for exactly the next cycle. On that same edge food_valid <= 0 and state -> PLACE.
- ARMED, game_state 01 or 11: hold food, ignore move_tick, never assert get_food.
- PLACE/CHECK while game_state is 01 or 11: freeze the state (LFSR still runs), query_valid held at 0. Resume when game_state returns to 00.
- move_tick outside ARMED: ignored; no get_food.
- get_food is never asserted unless game_state == 00 on the triggering cycle.
- Retries are unbounded. No cap; a full grid stalls in PLACE/CHECK.
- food_x/food_y hold their last value while food_valid = 0.

Test Plan:
- Assert rst, game_state = 10 -> all outputs 0, internal LFSR = 16'hACE1. Release rst -> state stays IDLE, no query_valid.
- game_state = 00, occ = 0, head (0,0) -> within 64 cycles: food_valid = 1, food_x < 40, food_y < 30. Every query_valid pulse carries cand_x < 40 and cand_y < 30.
- Armed food at (fx,fy); drive head = (fx,fy) with a 1-cycle move_tick -> get_food high exactly 1 cycle, food_valid = 0 on the same edge. New placement follows with a different LFSR-derived candidate.
- Force occ = 1 for the first 5 queries, then 0 -> food_valid stays 0 through 5 rejects. It rises in the cycle after the 6th CHECK, with food = the 6th candidate.
- Armed; game_state = 01, head = food, move_tick -> no get_food, food held. game_state = 10 -> food_valid = 0 next edge. Return to 00 -> fresh placement.
- Assert rst during CHECK -> outputs clear immediately without waiting for a clock. After release, a clean IDLE -> PLACE restart.

Source files
------------

// File: rtl/food_if.sv
// ----------------------------------------------------------------------------
// food_if : signal bundle between the snake game controller and food_unit.
//   master modport : game controller side (drives game_state, move_tick,
//                    head_x/head_y, occ; receives query/food/eat signals)
//   slave modport  : food_unit side (the mirror image)
// Signals:
//   game_state  2-bit shared game state (00 play, 01 pause, 10 restart, 11 over)
//   move_tick   one-cycle strobe, head_x/head_y just updated
//   head_x/y    snake head position
//   occ         body occupancy answer for the last query
//   query_valid one-cycle occupancy query strobe, cand_x/cand_y = cell asked
//   food_valid  food placed and live at food_x/food_y
//   get_food    one-cycle eat pulse for the score stage
// ----------------------------------------------------------------------------
interface food_if #(
   parameter int X_W = 6,
   parameter int Y_W = 5
);
   logic [1:0]     game_state;
   logic           move_tick;
   logic [X_W-1:0] head_x;
   logic [Y_W-1:0] head_y;
   logic           occ;
   logic           query_valid;
   logic [X_W-1:0] cand_x;
   logic [Y_W-1:0] cand_y;
   logic           food_valid;
   logic [X_W-1:0] food_x;
   logic [Y_W-1:0] food_y;
   logic           get_food;

   modport master (
      output game_state, move_tick, head_x, head_y, occ,
      input  query_valid, cand_x, cand_y, food_valid, food_x, food_y, get_food
   );

   modport slave (
      input  game_state, move_tick, head_x, head_y, occ,
      output query_valid, cand_x, cand_y, food_valid, food_x, food_y, get_food
   );
endinterface

// File: rtl/food_unit.sv
// ----------------------------------------------------------------------------
// food_unit : snake-game food manager.
//   Draws pseudo-random candidate cells from a 16-bit LFSR, asks the body
//   store whether each in-grid candidate is occupied (one-cycle query), arms
//   the first free cell that is not the head, and emits a one-cycle get_food
//   when the head lands on the food during a move tick while playing.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  food_if.slave (game_state, move_tick, head_x/y, occ in;
//        query_valid, cand_x/y, food_valid, food_x/y, get_food out)
// ----------------------------------------------------------------------------
module food_unit #(
   parameter int          GRID_W    = 40,
   parameter int          GRID_H    = 30,
   parameter int          X_W       = 6,
   parameter int          Y_W       = 5,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic   clk,
   input logic   rst,
   food_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLACE = 2'd1,
      ST_CHECK = 2'd2,
      ST_ARMED = 2'd3
   } state_t;

   localparam logic [1:0]   GS_PLAY    = 2'b00;
   localparam logic [1:0]   GS_RESTART = 2'b10;
   // one extra bit so a grid size equal to 2**W still compares correctly
   localparam logic [X_W:0] GRID_W_L   = GRID_W[X_W:0];
   localparam logic [Y_W:0] GRID_H_L   = GRID_H[Y_W:0];

   state_t         r_state;
   state_t         w_next_state;
   logic [15:0]    r_lfsr;
   logic [15:0]    w_lfsr_next;
   logic [X_W-1:0] w_lfsr_x;
   logic [Y_W-1:0] w_lfsr_y;
   logic           w_in_grid;
   logic           w_play;
   logic           w_restart;
   logic           w_reject;
   logic           w_eat;

   logic           r_query_valid, w_query_valid;
   logic [X_W-1:0] r_cand_x,      w_cand_x;
   logic [Y_W-1:0] r_cand_y,      w_cand_y;
   logic           r_food_valid,  w_food_valid;
   logic [X_W-1:0] r_food_x,      w_food_x;
   logic [Y_W-1:0] r_food_y,      w_food_y;
   logic           r_get_food,    w_get_food;

   // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
   assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_lfsr_x    = r_lfsr[X_W-1:0];
   assign w_lfsr_y    = r_lfsr[8+Y_W-1:8];
   assign w_in_grid   = ({1'b0, w_lfsr_x} < GRID_W_L) && ({1'b0, w_lfsr_y} < GRID_H_L);
   assign w_play      = (bus.game_state == GS_PLAY);
   assign w_restart   = (bus.game_state == GS_RESTART);
   // a candidate under the head is rejected even if the body store says free
   assign w_reject    = bus.occ || ((r_cand_x == bus.head_x) && (r_cand_y == bus.head_y));
   assign w_eat       = bus.move_tick && (bus.head_x == r_food_x) && (bus.head_y == r_food_y);

   // State, LFSR and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_lfsr        <= LFSR_SEED;
         r_query_valid <= 1'b0;
         r_cand_x      <= '0;
         r_cand_y      <= '0;
         r_food_valid  <= 1'b0;
         r_food_x      <= '0;
         r_food_y      <= '0;
         r_get_food    <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_lfsr        <= w_lfsr_next;
         r_query_valid <= w_query_valid;
         r_cand_x      <= w_cand_x;
         r_cand_y      <= w_cand_y;
         r_food_valid  <= w_food_valid;
         r_food_x      <= w_food_x;
         r_food_y      <= w_food_y;
         r_get_food    <= w_get_food;
      end
   end

   // Next-state logic; restart wins over everything, pause/over freezes
   always_comb begin
      w_next_state = r_state;
      if (w_restart) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_play) w_next_state = ST_PLACE;
               else        w_next_state = ST_IDLE;
            end
            ST_PLACE: begin
               if (w_play && w_in_grid) w_next_state = ST_CHECK;
               else                     w_next_state = ST_PLACE;
            end
            ST_CHECK: begin
               if (!w_play)       w_next_state = ST_CHECK;
               else if (w_reject) w_next_state = ST_PLACE;
               else               w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
               if (w_play && w_eat) w_next_state = ST_PLACE;
               else                 w_next_state = ST_ARMED;
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs; pulses default low, data holds
   always_comb begin
      w_query_valid = 1'b0;
      w_get_food    = 1'b0;
      w_cand_x      = r_cand_x;
      w_cand_y      = r_cand_y;
      w_food_valid  = r_food_valid;
      w_food_x      = r_food_x;
      w_food_y      = r_food_y;
      if (w_restart) begin
         w_food_valid = 1'b0;
      end else begin
         case (r_state)
            ST_PLACE: begin
               if (w_play && w_in_grid) begin
                  w_cand_x      = w_lfsr_x;
                  w_cand_y      = w_lfsr_y;
                  w_query_valid = 1'b1;
               end else begin
                  w_query_valid = 1'b0;
               end
            end
            ST_CHECK: begin
               if (w_play && !w_reject) begin
                  w_food_x     = r_cand_x;
                  w_food_y     = r_cand_y;
                  w_food_valid = 1'b1;
               end else begin
                  w_food_valid = r_food_valid;
               end
            end
            ST_ARMED: begin
               if (w_play && w_eat) begin
                  w_get_food   = 1'b1;
                  w_food_valid = 1'b0;
               end else begin
                  w_get_food   = 1'b0;
               end
            end
            default: begin
               w_get_food = 1'b0;
            end
         endcase
      end
   end

   assign bus.query_valid = r_query_valid;
   assign bus.cand_x      = r_cand_x;
   assign bus.cand_y      = r_cand_y;
   assign bus.food_valid  = r_food_valid;
   assign bus.food_x      = r_food_x;
   assign bus.food_y      = r_food_y;
   assign bus.get_food    = r_get_food;

endmodule

// File: tb/tb_food_unit.sv
// ----------------------------------------------------------------------------
// tb_food_unit : self-checking bench for food_unit.
//   Directed vector table from reset (hand-derived LFSR candidates), directed
//   sequences for occupancy retries and reset during CHECK, then randomized
//   stimulus against a rule-level reference model.
// ----------------------------------------------------------------------------
module tb_food_unit;
   localparam int X_W = 6;
   localparam int Y_W = 5;
   localparam int GRID_W = 40;
   localparam int GRID_H = 30;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   food_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

   food_unit #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]     gs;
      logic           mt;
      logic [X_W-1:0] hx;
      logic [Y_W-1:0] hy;
      logic           occ;
      logic           qv;
      logic [X_W-1:0] cx;
      logic [Y_W-1:0] cy;
      logic           fv;
      logic [X_W-1:0] fx;
      logic [Y_W-1:0] fy;
      logic           gf;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic [1:0] gs, input logic mt, input int hx, input int hy,
                               input logic occ, input logic qv, input int cx, input int cy,
                               input logic fv, input int fx, input int fy, input logic gf);
      vec_t v;
      v.gs = gs; v.mt = mt; v.hx = hx[X_W-1:0]; v.hy = hy[Y_W-1:0]; v.occ = occ;
      v.qv = qv; v.cx = cx[X_W-1:0]; v.cy = cy[Y_W-1:0];
      v.fv = fv; v.fx = fx[X_W-1:0]; v.fy = fy[Y_W-1:0]; v.gf = gf;
      return v;
   endfunction

   function automatic logic [24:0] dut_outs();
      return {bus.query_valid, bus.cand_x, bus.cand_y, bus.food_valid,
              bus.food_x, bus.food_y, bus.get_food};
   endfunction

   // ---------------- reference model (game rules, plain variables) ---------
   localparam int P_IDLE = 0, P_SEARCH = 1, P_ASK = 2, P_FOOD = 3;
   logic [15:0]    m_lfsr;
   int             m_phase;
   logic           m_qv, m_fv, m_gf;
   logic [X_W-1:0] m_cx, m_fx;
   logic [Y_W-1:0] m_cy, m_fy;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], ^(v & 16'hB400)};
   endfunction

   task automatic model_reset();
      m_lfsr = 16'hACE1; m_phase = P_IDLE;
      m_qv = 1'b0; m_fv = 1'b0; m_gf = 1'b0;
      m_cx = '0; m_cy = '0; m_fx = '0; m_fy = '0;
   endtask

   // one clock edge worth of game rules, using the inputs currently driven
   task automatic model_step();
      int x, y;
      x = int'(m_lfsr[5:0]);
      y = int'(m_lfsr[12:8]);
      m_qv = 1'b0;
      m_gf = 1'b0;
      if (bus.game_state == 2'b10) begin
         m_phase = P_IDLE;
         m_fv = 1'b0;
      end else if (bus.game_state == 2'b00) begin
         if (m_phase == P_IDLE) begin
            m_phase = P_SEARCH;
         end else if (m_phase == P_SEARCH) begin
            if (x < GRID_W && y < GRID_H) begin
               m_cx = x[X_W-1:0]; m_cy = y[Y_W-1:0]; m_qv = 1'b1; m_phase = P_ASK;
            end
         end else if (m_phase == P_ASK) begin
            if (bus.occ || (bus.head_x == m_cx && bus.head_y == m_cy)) begin
               m_phase = P_SEARCH;
            end else begin
               m_fx = m_cx; m_fy = m_cy; m_fv = 1'b1; m_phase = P_FOOD;
            end
         end else begin
            if (bus.move_tick && bus.head_x == m_fx && bus.head_y == m_fy) begin
               m_gf = 1'b1; m_fv = 1'b0; m_phase = P_SEARCH;
            end
         end
      end
      m_lfsr = lfsr_step(m_lfsr);
   endtask

   task automatic drive(input logic [1:0] gs, input logic mt, input logic [X_W-1:0] hx,
                        input logic [Y_W-1:0] hy, input logic occ);
      bus.game_state = gs; bus.move_tick = mt;
      bus.head_x = hx; bus.head_y = hy; bus.occ = occ;
   endtask

   // async reset pulse between clock edges; LFSR restarts at the seed
   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int qcount, q6_cycle, fv_cycle, found;
      logic [X_W-1:0] c6x;
      logic [Y_W-1:0] c6y;
      logic early_fv, range_bad;

      // table: inputs for edge k, outputs expected after edge k
      vecs[0]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b0,  0,  0, 1'b0,  0, 0, 1'b0);
      vecs[1]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b1,  3, 25, 1'b0,  0, 0, 1'b0);
      vecs[2]  = mk(2'b00, 1'b0,  0,  0, 1'b1, 1'b0,  3, 25, 1'b0,  0, 0, 1'b0);
      vecs[3]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b1, 15,  7, 1'b0,  0, 0, 1'b0);
      vecs[4]  = mk(2'b00, 1'b0, 15,  7, 1'b0, 1'b0, 15,  7, 1'b0,  0, 0, 1'b0);
      vecs[5]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b0, 15,  7, 1'b0,  0, 0, 1'b0);
      vecs[6]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b0, 15,  7, 1'b0,  0, 0, 1'b0);
      vecs[7]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b0, 15,  7, 1'b0,  0, 0, 1'b0);
      vecs[8]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b1, 36,  1, 1'b0,  0, 0, 1'b0);
      vecs[9]  = mk(2'b00, 1'b0,  0,  0, 1'b0, 1'b0, 36,  1, 1'b1, 36, 1, 1'b0);
      vecs[10] = mk(2'b01, 1'b1, 36,  1, 1'b0, 1'b0, 36,  1, 1'b1, 36, 1, 1'b0);
      vecs[11] = mk(2'b00, 1'b1, 36,  1, 1'b0, 1'b0, 36,  1, 1'b0, 36, 1, 1'b1);
      vecs[12] = mk(2'b10, 1'b0,  0,  0, 1'b0, 1'b0, 36,  1, 1'b0, 36, 1, 1'b0);

      // reset with restart state
      rst = 1'b1;
      drive(2'b10, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", {7'd0, dut_outs()}, 32'd0);
      chk("reset_lfsr", {16'd0, dut.r_lfsr}, 32'h0000ACE1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_no_query", {30'd0, bus.query_valid, bus.food_valid}, 32'd0);
      end

      // directed vector table from a fresh reset
      pulse_reset();
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].gs, vecs[i].mt, vecs[i].hx, vecs[i].hy, vecs[i].occ);
         @(negedge clk);
         chk($sformatf("vec%0d", i), {7'd0, dut_outs()},
             {7'd0, vecs[i].qv, vecs[i].cx, vecs[i].cy, vecs[i].fv, vecs[i].fx, vecs[i].fy, vecs[i].gf});
      end

      // occupied for the first 5 queries, then free
      pulse_reset();
      drive(2'b00, 1'b0, 6'd63, 5'd31, 1'b1);
      qcount = 0; q6_cycle = -1; fv_cycle = -1; early_fv = 1'b0; range_bad = 1'b0;
      c6x = '0; c6y = '0;
      for (int c = 0; c < 400 && fv_cycle < 0; c++) begin
         @(negedge clk);
         if (bus.food_valid) fv_cycle = c;
         else if (bus.query_valid) begin
            qcount++;
            if (bus.cand_x >= 6'(GRID_W) || bus.cand_y >= 5'(GRID_H)) range_bad = 1'b1;
            bus.occ = (qcount <= 5);
            if (qcount == 6) begin
               q6_cycle = c; c6x = bus.cand_x; c6y = bus.cand_y;
            end
         end
         if (bus.food_valid && qcount < 6) early_fv = 1'b1;
      end
      chk("occ_food_seen", {31'd0, fv_cycle >= 0}, 32'd1);
      chk("occ_no_early_food", {31'd0, early_fv}, 32'd0);
      chk("occ_query_range", {31'd0, range_bad}, 32'd0);
      chk("occ_rise_timing", 32'(fv_cycle - q6_cycle), 32'd1);
      chk("occ_food_is_6th", {21'd0, bus.food_x, bus.food_y}, {21'd0, c6x, c6y});

      // reset during CHECK clears outputs without a clock edge
      drive(2'b10, 1'b0, 6'd63, 5'd31, 1'b0);
      @(negedge clk);
      bus.game_state = 2'b00;
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (bus.query_valid) found = 1;
      end
      chk("check_reached", 32'(found), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_clear", {7'd0, dut_outs()}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_idle_to_place", {31'd0, bus.query_valid}, 32'd0);
      @(negedge clk);
      chk("restart_first_query", {20'd0, bus.query_valid, bus.cand_x, bus.cand_y}, {20'd0, 1'b1, 6'd3, 5'd25});

      // randomized run against the reference model
      pulse_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         int r;
         logic [1:0] gs;
         logic [X_W-1:0] hx;
         logic [Y_W-1:0] hy;
         r = int'($urandom_range(0, 99));
         gs = (r < 75) ? 2'b00 : (r < 85) ? 2'b01 : (r < 96) ? 2'b11 : 2'b10;
         r = int'($urandom_range(0, 99));
         if (m_fv && r < 50) begin
            hx = m_fx; hy = m_fy;
         end else if (m_phase == P_ASK && r < 70) begin
            hx = m_cx; hy = m_cy;
         end else begin
            hx = 6'($urandom_range(0, 45)); hy = 5'($urandom_range(0, 31));
         end
         drive(gs, ($urandom_range(0, 99) < 40), hx, hy, ($urandom_range(0, 99) < 30));
         model_step();
         @(negedge clk);
         chk("rand_outputs", {7'd0, dut_outs()},
             {7'd0, m_qv, m_cx, m_cy, m_fv, m_fx, m_fy, m_gf});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
